zeroheti_imem_arbiter: RTL
==========================

# zeroheti_imem_arbiter

Two-requester OBI arbiter that shares the single instruction-memory subordinate port between the core fetch interface and the debug system-bus manager. It decides which requester reaches memory each cycle, tracks outstanding transactions in order, and routes each response back to the requester that issued it. It sits in the core crossbar between the fetch/SBA managers and the instruction-memory port.

## Interface
- `NumMaxTrans`, default 2: maximum outstanding accepted requests; sets routing-FIFO depth (1..4).
- `MaxWait`, default 8: cycles an SBA request may stall before it is forced to win. Used only with the anti-starvation feature.
- `AddrWidth`, default 32: address width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `if_req_i` in 1, `if_addr_i` in AddrWidth: fetch request. Fetch is read-only.
- `if_gnt_o` out 1, `if_rvalid_o` out 1, `if_rdata_o` out 32, `if_err_o` out 1: fetch grant and response.
- `sba_req_i` in 1, `sba_we_i` in 1, `sba_be_i` in 4, `sba_addr_i` in AddrWidth, `sba_wdata_i` in 32: SBA request.
- `sba_gnt_o` out 1, `sba_rvalid_o` out 1, `sba_rdata_o` out 32, `sba_err_o` out 1: SBA grant and response.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_be_o` out 4, `mem_addr_o` out AddrWidth, `mem_wdata_o` out 32: memory request.
- `mem_gnt_i` in 1, `mem_rvalid_i` in 1, `mem_rdata_i` in 32, `mem_err_i` in 1: memory grant and response.

## Operation
- Arbitration is combinational each cycle.
  - Fetch has fixed priority.
  - SBA wins when fetch is idle, or when the anti-starvation override is active.
- The winner's request fields drive `mem_*`.
  - Fetch drives `mem_we_o=0` and `mem_be_o=4'hF`.
  - With no winner, `mem_req_o=0` and the other `mem_*` outputs are 0.
- `mem_req_o` is asserted only when the routing FIFO is not full.
  - A full FIFO blocks new requests even if a response pops in the same cycle.
- Grant: `x_gnt_o = winner==x & mem_req_o & mem_gnt_i`.
  - The loser's gnt is 0.
- Handshake rules on each requester:
  - A request is accepted on `req & gnt`.
  - Requesters must hold `req` and all fields stable until gnt.
  - The arbiter may change the winner between cycles while a request is ungranted. OBI permits this because `mem_req_o` is not required to be sticky per source.
- Routing FIFO:
  - 1-bit source-ID FIFO, depth `NumMaxTrans`.
  - Push on an accepted memory request.
  - Pop on `mem_rvalid_i`.
  - Memory returns exactly one in-order rvalid per accepted request.
- Response steering:
  - The FIFO head ID steers `mem_rvalid_i`/`mem_rdata_i`/`mem_err_i` to the matching requester.
  - The other requester sees rvalid=0, rdata=0, err=0.
- Push and pop in the same cycle leave the count unchanged. The pointers wrap modulo `NumMaxTrans`.
- `mem_rvalid_i` while the FIFO is empty is a protocol error.
  - It is ignored: no output rvalid, and the count does not underflow.
  - It is flagged by an assertion in simulation.

## Timing
- Request path is zero latency: requester req/fields to `mem_*`, and `mem_gnt_i` to `x_gnt_o`, in the same cycle.
- Response path is zero latency: `mem_rvalid_i` to `x_rvalid_o` in the same cycle, combinational through the FIFO head.
- Reset value of every output is 0.
- On reset:
  - FIFO count and pointers are 0.
  - The wait counter is 0.
- Reset asserted mid-transaction discards all outstanding IDs. Memory must be reset by the same `rst_i`.
- Wait counter (anti-starvation builds only):
  - Increments each cycle `sba_req_i & ~sba_gnt_o`.
  - Saturates at `MaxWait`.
  - Clears on `sba_gnt_o` or `~sba_req_i`.
- Override is active when counter == `MaxWait`.
  - SBA becomes the winner and stays the winner until granted.

## Configuration
- Macro: `ZEROHETI_IMEM_ARB_ANTISTARVE_EN`.
- Defined: the wait counter and override are present, so an SBA request is granted no later than `MaxWait`+1 cycles after memory becomes grantable.
- Undefined: the counter logic is absent and fetch has strict priority. SBA can starve under continuous fetch; `MaxWait` is unused.

## Test plan
- Fetch alone, addr 0x100, mem gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> `if_gnt_o`=1 in cycle 0; `if_rvalid_o`=1 with 0xDEADBEEF in cycle 1; `sba_rvalid_o` stays 0.
- Fetch and SBA (write 0x200, data 0x12345678, be 0x3) both request for one cycle -> fetch granted first, SBA granted the next cycle with `mem_we_o`=1 and `mem_be_o`=0x3; responses return in order to fetch, then to SBA.
- `NumMaxTrans`=2, memory withholds rvalid for 3 cycles -> two fetches granted, third request sees `mem_req_o`=0 until the first rvalid pops, then is accepted one cycle later.
- Continuous fetch plus SBA request, `MaxWait`=8, with the feature defined -> `sba_gnt_o`=1 on the 9th cycle. With the feature undefined, `sba_gnt_o` never asserts.
- `mem_rvalid_i` with `mem_err_i`=1 for an SBA read -> `sba_err_o`=1 together with `sba_rvalid_o`; `if_err_o`=0.
- `rst_i` asserted with 2 transactions outstanding, then released -> all outputs 0 during reset; the FIFO is empty afterwards and a new fetch completes normally.

Source files
------------

// File: rtl/zeroheti_imem_arbiter.sv
// Two-requester OBI arbiter: core fetch and debug SBA share one instruction-memory port.
// Define ZEROHETI_IMEM_ARB_ANTISTARVE_EN to add the SBA wait counter and forced-win override.
module zeroheti_imem_arbiter #(
  parameter int unsigned NumMaxTrans = 2,
  parameter int unsigned MaxWait     = 8,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic [AddrWidth-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [31:0]          if_rdata_o,
  output logic                 if_err_o,
  input  logic                 sba_req_i,
  input  logic                 sba_we_i,
  input  logic [3:0]           sba_be_i,
  input  logic [AddrWidth-1:0] sba_addr_i,
  input  logic [31:0]          sba_wdata_i,
  output logic                 sba_gnt_o,
  output logic                 sba_rvalid_o,
  output logic [31:0]          sba_rdata_o,
  output logic                 sba_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_err_i
);

  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  typedef enum logic [1:0] {WinNone, WinIf, WinSba} win_e;

  win_e                   win;
  logic                   override;
  logic                   full, empty, push, pop, head_sba;
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NumMaxTrans-1:0] ids_q, ids_d;

  assign full  = (cnt_q == CntW'(NumMaxTrans));
  assign empty = (cnt_q == '0);

`ifdef ZEROHETI_IMEM_ARB_ANTISTARVE_EN
  localparam int unsigned WaitW = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
  logic [WaitW-1:0] wait_q, wait_d;

  assign override = sba_req_i && (wait_q == WaitW'(MaxWait));

  always_comb begin
    wait_d = '0;
    if (sba_req_i && !sba_gnt_o) begin
      wait_d = (wait_q == WaitW'(MaxWait)) ? wait_q : wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign override = 1'b0;
`endif

  // Arbitration and request mux; reset forces "no winner" so every output reads 0.
  always_comb begin
    win = WinNone;
    if (!rst_i) begin
      if (override)       win = WinSba;
      else if (if_req_i)  win = WinIf;
      else if (sba_req_i) win = WinSba;
    end

    mem_req_o   = (win != WinNone) && !full;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (win)
      WinIf: begin
        mem_be_o   = 4'hF;
        mem_addr_o = if_addr_i;
      end
      WinSba: begin
        mem_we_o    = sba_we_i;
        mem_be_o    = sba_be_i;
        mem_addr_o  = sba_addr_i;
        mem_wdata_o = sba_wdata_i;
      end
      default: ;
    endcase

    if_gnt_o  = (win == WinIf)  && mem_req_o && mem_gnt_i;
    sba_gnt_o = (win == WinSba) && mem_req_o && mem_gnt_i;
  end

  // Routing FIFO of source IDs (1 = SBA); a stray rvalid on an empty FIFO is dropped.
  always_comb begin
    push     = mem_req_o && mem_gnt_i;
    pop      = mem_rvalid_i && !empty;
    head_sba = ids_q[rptr_q];
    ids_d    = ids_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      ids_d[wptr_q] = (win == WinSba);
      wptr_d = (wptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: ;
    endcase

    if_rvalid_o  = pop && !head_sba;
    if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    if_err_o     = if_rvalid_o && mem_err_i;
    sba_rvalid_o = pop && head_sba;
    sba_rdata_o  = sba_rvalid_o ? mem_rdata_i : '0;
    sba_err_o    = sba_rvalid_o && mem_err_i;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: ID storage needs no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    ids_q <= ids_d;
  end

`ifndef SYNTHESIS
  rvalid_without_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && empty));
`endif

endmodule
